seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode seven-segment display. A single shared seven-segment decoder drives all four digits. The controller latches a 16-bit hex value (four nibbles) plus per-digit decimal points, sequences one digit at a time onto the decoder's digit-code and decimal inputs, and drives the active-low anode enables. It inserts an all-off guard interval between digits to prevent ghosting, and commits new values only at frame boundaries so a frame never shows a torn value.

## Interface
- DWELL, 50000, clock cycles each digit is lit (≥1)
- GUARD, 16, clock cycles all anodes off between digits (≥1)
- LZB, 1, leading-zero blanking enable (1 = on)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- enable  in  1  scan enable; 0 blanks the display
- value_in  in  16  hex value; nibble i shown on digit i (digit 0 = rightmost)
- dp_in  in  4  decimal point per digit, 1 = lit
- load  in  1  capture value_in/dp_in this cycle
- load_ack  out  1  one-cycle pulse when a pending load is committed to display
- frame_tick  out  1  one-cycle pulse at the end of each complete frame
- dig_code  out  4  to decoder digit input; 4'hd = blank (space)
- dig_dp  out  1  to decoder decimal input; 1 = dp lit
- anode_n  out  4  anode enables, active-low, at most one low

## Operation
- Registers:
  - pending value/dp plus pend flag
  - shadow value/dp (displayed)
  - index[1:0]
  - state (GUARD/SHOW)
  - cycle counter sized $clog2(max(DWELL,GUARD))
- Reset values: anode_n=4'b1111, dig_code=4'hd, dig_dp=0, load_ack=0, frame_tick=0, shadow=0, dp shadow=0, pend=0, index=0, state=GUARD, counter=0.
- load=1: pending <= {value_in, dp_in} and pend <= 1. A later load in the same frame overwrites the earlier one (last write wins).
- GUARD state:
  - anode_n=1111, dig_code=4'hd, dig_dp=0.
  - After GUARD cycles, go to SHOW.
- SHOW state:
  - anode_n[index]=0.
  - dig_code = shadow nibble[index], or 4'hd if that digit is blanked.
  - dig_dp = shadow dp[index].
  - After DWELL cycles, go to GUARD and set index <= index+1 (wraps 3→0).
- Frame commit: on the cycle leaving SHOW with index=3:
  - frame_tick=1.
  - If pend: shadow <= pending, pend <= 0, load_ack=1.
  - If load is also high that cycle: the previous pending value commits, the new value becomes pending and pend stays 1.
- Blanking (LZB=1): digit i (i=1..3) is blanked when shadow nibbles i..3 are all zero. Digit 0 is never blanked. dp is unaffected by blanking. With LZB=0, no digit is blanked.
- enable=0:
  - Next cycle: state=GUARD, counter=0, anode_n=1111, index held.
  - frame_tick and load_ack are not pulsed. Loads are still captured.
  - When enable returns to 1: a full GUARD interval, then SHOW of the held index.
- rst_n asserted at any point: all outputs and registers take reset values immediately, and any pending load is discarded.

## Timing
- All outputs are registered. anode_n, dig_code and dig_dp change on the same edge.
- Frame period = 4×(DWELL+GUARD) cycles.
- First lit digit appears GUARD cycles after reset release: digit 0, blank code 4'hd for value 0 under LZB… digit 0 shows 4'h0.
- Load-to-display latency: commit occurs at the end of the current frame. The new value appears at the SHOW of digit 0, GUARD cycles after load_ack.
- load_ack and frame_tick coincide and are each exactly 1 cycle wide.

## Test plan
All scenarios use DWELL=4, GUARD=2, LZB=1.

- **Reset and scan:** hold rst_n low then release.
  - During reset: anode_n=1111, dig_code=d.
  - After release: 2 cycles 1111; 4 cycles 1110 with code 0; 2 cycles 1111; then 1101, 1011, 0111 with code d on each; frame_tick pulses every 24 cycles.
- **Mid-frame load:** load 16'h1234 with dp 4'b0100 mid-frame.
  - The current frame still shows the old value.
  - load_ack pulses together with frame_tick.
  - The next frame shows codes 4,3,2,1 on digits 0..3, with dig_dp=1 only on digit 2.
- **Leading-zero blanking:**
  - Load 16'h0050: digits 3,2 show d; digit 1 shows 5; digit 0 shows 0.
  - Load 16'h0000: digit 0 shows 0; digits 1–3 show d.
- **Load coalescing:**
  - Loads of 16'h1111 then 16'h2222 within one frame: exactly one load_ack, and 2222 is displayed.
  - Load 16'h3333 on the commit cycle while 16'h4444 is pending: 4444 commits; 3333 commits one frame later with a second ack.
- **Enable drop:** drop enable while anode_n=1011.
  - Next cycle: anode_n=1111, with no tick or ack.
  - Re-enable: 2 guard cycles, then 1011 for 4 cycles.
- **Reset mid-frame:** assert rst_n mid-SHOW with a load pending.
  - All outputs return to reset values immediately.
  - After release, digit 0 shows 0 and no load_ack occurs.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display sharing one decoder.
// It sequences guard/show slots per digit and commits new values only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int GUARD = 16,
  parameter bit LZB   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  dig_code,
  output logic        dig_dp,
  output logic [3:0]  anode_n
);

  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [3:0]    BLANK      = 4'hd;

  typedef enum logic {S_GUARD, S_SHOW} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    index;
  logic [15:0]   pend_value, shadow_value;
  logic [3:0]    pend_dp, shadow_dp;
  logic          pend;

  logic [3:0]    blank;
  logic [3:0]    lit_code;
  logic          lit_dp;

  // Digit i blanks when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    blank = 4'b0000;
    if (LZB) begin
      blank[1] = (shadow_value[15:4]  == 12'h000);
      blank[2] = (shadow_value[15:8]  == 8'h00);
      blank[3] = (shadow_value[15:12] == 4'h0);
    end
    lit_code = blank[index] ? BLANK : shadow_value[{index, 2'b00} +: 4];
    lit_dp   = shadow_dp[index];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_GUARD;
      count        <= '0;
      index        <= 2'd0;
      pend_value   <= 16'h0000;
      pend_dp      <= 4'b0000;
      pend         <= 1'b0;
      shadow_value <= 16'h0000;
      shadow_dp    <= 4'b0000;
      anode_n      <= 4'b1111;
      dig_code     <= BLANK;
      dig_dp       <= 1'b0;
      load_ack     <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;

      if (load) begin
        pend_value <= value_in;
        pend_dp    <= dp_in;
        pend       <= 1'b1;
      end

      if (!enable) begin
        state    <= S_GUARD;
        count    <= '0;
        anode_n  <= 4'b1111;
        dig_code <= BLANK;
        dig_dp   <= 1'b0;
      end else if (state == S_GUARD) begin
        if (count == GUARD_LAST) begin
          state    <= S_SHOW;
          count    <= '0;
          anode_n  <= ~(4'b0001 << index);
          dig_code <= lit_code;
          dig_dp   <= lit_dp;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        if (count == DWELL_LAST) begin
          state    <= S_GUARD;
          count    <= '0;
          index    <= index + 2'd1;
          anode_n  <= 4'b1111;
          dig_code <= BLANK;
          dig_dp   <= 1'b0;
          if (index == 2'd3) begin
            frame_tick <= 1'b1;
            if (pend) begin
              // Old pending commits; a same-cycle load (captured above) stays pending.
              shadow_value <= pend_value;
              shadow_dp    <= pend_dp;
              load_ack     <= 1'b1;
              pend         <= load;
            end
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DWELL=4, GUARD=2, LZB=1.
// A frame-position model predicts every output cycle; displayed codes come from table constants.
module tb_seg_scan_ctrl;

  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DWELL + GUARD;
  localparam int FRAME = 4 * SLOT;
  localparam logic [10:0] RESET_B = {4'b1111, 4'hd, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n, enable, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_ack, frame_tick, dig_dp;
  logic [3:0]  dig_code, anode_n;
  logic [10:0] obs;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DWELL(DWELL), .GUARD(GUARD), .LZB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .load_ack(load_ack), .frame_tick(frame_tick), .dig_code(dig_code),
    .dig_dp(dig_dp), .anode_n(anode_n)
  );

  assign obs = {anode_n, dig_code, dig_dp, frame_tick, load_ack};

  typedef struct packed {
    logic [15:0] codes;   // expected decoder code per digit, digit 3 in the top nibble
    logic [3:0]  dp;
  } disp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [15:0] codes;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t        vecs[3];
  disp_t       pend_q[$];
  logic [10:0] exp_q[$];
  disp_t       cur;
  int          k;
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_seen = 0;
  int          a0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
    enable   = en;
    load     = ld;
    value_in = v;
    dp_in    = d;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (load_ack) ack_seen++;
  endtask

  // One enabled clock: predict the post-edge outputs, apply the edge, compare.
  task automatic model_step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                            input disp_t nd);
    int          kn, pos, dig;
    logic        lit, tk, ak;
    logic [10:0] e;
    kn  = k + 1;
    pos = kn % FRAME;
    dig = pos / SLOT;
    lit = (pos % SLOT) >= GUARD;
    tk  = (pos == 0);
    ak  = 1'b0;
    if (tk && pend_q.size() > 0) begin
      ak  = 1'b1;
      cur = pend_q.pop_front();
    end
    if (ld) begin
      if (pend_q.size() > 0) void'(pend_q.pop_back());
      pend_q.push_back(nd);
    end
    e = lit ? {~(4'b0001 << dig), cur.codes[dig*4 +: 4], cur.dp[dig], tk, ak}
            : {4'b1111, 4'hd, 1'b0, tk, ak};
    exp_q.push_back(e);
    drive(1'b1, ld, v, d);
    k = kn;
    check($sformatf("scan k=%0d", k), {21'd0, obs}, {21'd0, exp_q.pop_front()});
  endtask

  task automatic idle();
    model_step(1'b0, 16'h0000, 4'h0, '0);
  endtask

  task automatic run_to(input int p);
    do idle(); while (k % FRAME != p);
  endtask

  task automatic load_at(input logic [15:0] v, input logic [3:0] d, input logic [15:0] codes);
    disp_t nd;
    nd.codes = codes;
    nd.dp    = d;
    model_step(1'b1, v, d, nd);
  endtask

  task automatic restart_model();
    k = 0;
    cur.codes = 16'hddd0;
    cur.dp    = 4'h0;
    pend_q.delete();
  endtask

  initial begin
    vecs[0] = '{value: 16'h1234, dp: 4'b0100, codes: 16'h1234, exp_dp: 4'b0100};
    vecs[1] = '{value: 16'h0050, dp: 4'b0000, codes: 16'hdd50, exp_dp: 4'b0000};
    vecs[2] = '{value: 16'h0000, dp: 4'b0000, codes: 16'hddd0, exp_dp: 4'b0000};

    rst_n = 1'b0; enable = 1'b1; load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
    repeat (3) @(posedge clk);
    #1 check("during_reset", {21'd0, obs}, {21'd0, RESET_B});
    @(negedge clk) rst_n = 1'b1;
    restart_model();
    check("at_release", {21'd0, obs}, {21'd0, RESET_B});
    run_to(0);
    run_to(0);

    // Mid-frame loads: old value finishes its frame, the new one shows a frame later.
    for (int i = 0; i < 3; i++) begin
      run_to(8);
      model_step(1'b1, vecs[i].value, vecs[i].dp, '{codes: vecs[i].codes, dp: vecs[i].exp_dp});
      run_to(0);
      run_to(0);
    end

    // Two loads in one frame coalesce into a single ack.
    a0 = ack_seen;
    run_to(4);
    load_at(16'h1111, 4'h0, 16'h1111);
    run_to(10);
    load_at(16'h2222, 4'h0, 16'h2222);
    run_to(0);
    run_to(0);
    check("coalesce_acks", ack_seen - a0, 1);

    // Load landing on the commit edge while another is pending.
    a0 = ack_seen;
    run_to(8);
    load_at(16'h4444, 4'h0, 16'h4444);
    run_to(FRAME - 1);
    load_at(16'h3333, 4'h0, 16'h3333);
    run_to(0);
    run_to(0);
    check("commit_edge_acks", ack_seen - a0, 2);

    // Enable drop while digit 2 is lit; the model resumes at the same frame position.
    run_to(14);
    drive(1'b0, 1'b0, 16'h0, 4'h0);
    check("disable_blank", {21'd0, obs}, {21'd0, RESET_B});
    drive(1'b0, 1'b0, 16'h0, 4'h0);
    check("disable_hold", {21'd0, obs}, {21'd0, RESET_B});
    drive(1'b1, 1'b0, 16'h0, 4'h0);
    check("reenable_guard", {21'd0, obs}, {21'd0, RESET_B});
    drive(1'b1, 1'b0, 16'h0, 4'h0);
    check("reenable_show", {21'd0, obs}, {21'd0, 4'b1011, 4'h3, 1'b0, 2'b00});
    run_to(0);

    // Asynchronous reset mid-SHOW with a load pending.
    run_to(16);
    load_at(16'h5678, 4'hf, 16'h5678);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {21'd0, obs}, {21'd0, RESET_B});
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    restart_model();
    check("post_reset", {21'd0, obs}, {21'd0, RESET_B});
    a0 = ack_seen;
    run_to(0);
    run_to(0);
    check("no_ack_after_reset", ack_seen - a0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
